// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default 640x480@60 timing constants and a window helper
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV   = 2;
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Half-open window test lo <= v < hi on 10-bit counter values.
  function automatic logic in_window(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_pix_div.sv
`default_nettype none
// ============================================================================
// vga_pix_div : CLK-to-pixel divider producing pix_en and pixel_clk
// Rev 1.0
// ============================================================================
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RESET,
  output logic pix_en,
  output logic pixel_clk
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // With CLK_DIV=1 DIV_LAST and DIV_HALF are both 0, so div stays 0,
  // pix_en is constantly 1 and pixel_clk constantly 0.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en    = (div_q == DIV_LAST);
  assign pixel_clk = (div_q < DIV_HALF);

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : VGA raster timing (sync, blank, coordinates, frame strobes)
// Rev 1.0
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       pixel_clk,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       vsync_toggle
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       vsync_toggle_q, vsync_toggle_d;
  logic       h_wrap;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .CLK      (CLK),
    .RESET    (RESET),
    .pix_en   (pix_en),
    .pixel_clk(pixel_clk)
  );

  // Sync and blank decode the next-state counters so they register
  // alongside DrawX/DrawY with no skew.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    h_wrap = pix_en && (x_q == H_LAST);
    if (pix_en) begin
      x_d = h_wrap ? '0 : x_q + 10'd1;
      if (h_wrap) begin
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end
    end
    hs_d           = !in_window(x_d, HS_START, HS_END);
    vs_d           = !in_window(y_d, VS_START, VS_END);
    blank_d        = (x_d < H_VIS) && (y_d < V_VIS);
    line_tick_d    = h_wrap;
    frame_tick_d   = h_wrap && (y_q == V_LAST);
    vsync_toggle_d = vsync_toggle_q ^ (h_wrap && (y_d == VS_START));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q            <= '0;
      y_q            <= '0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      blank_q        <= 1'b1;
      line_tick_q    <= 1'b0;
      frame_tick_q   <= 1'b0;
      vsync_toggle_q <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      blank_q        <= blank_d;
      line_tick_q    <= line_tick_d;
      frame_tick_q   <= frame_tick_d;
      vsync_toggle_q <= vsync_toggle_d;
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign blank        = blank_q;
  assign line_tick    = line_tick_q;
  assign frame_tick   = frame_tick_q;
  assign vsync_toggle = vsync_toggle_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : directed bench for vga_sync_gen (default and reduced timing)
// Rev 1.0
// ============================================================================
module tb_vga_sync_gen;

  typedef struct packed {
    logic       pclk;
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       lt;
    logic       ft;
    logic       tog;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  // Reduced timing: 15 px/line (hs low x=10..12), 12 lines (vs low y=8..9).
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pclk_a, pe_a, hs_a, vs_a, blank_a, lt_a, ft_a, tog_a;
  logic [9:0] x_a, y_a;
  logic       pclk_s, pe_s, hs_s, vs_s, blank_s, lt_s, ft_s, tog_s;
  logic [9:0] x_s, y_s;
  logic       pclk_1, pe_1, hs_1, vs_1, blank_1, lt_1, ft_1, tog_1;
  logic [9:0] x_1, y_1;

  out_t got_a, got_s, got_1;
  assign got_a = {pclk_a, pe_a, x_a, y_a, hs_a, vs_a, blank_a, lt_a, ft_a, tog_a};
  assign got_s = {pclk_s, pe_s, x_s, y_s, hs_s, vs_s, blank_s, lt_s, ft_s, tog_s};
  assign got_1 = {pclk_1, pe_1, x_1, y_1, hs_1, vs_1, blank_1, lt_1, ft_1, tog_1};

  vga_sync_gen dut (
    .CLK(clk), .RESET(rst), .pixel_clk(pclk_a), .pix_en(pe_a), .DrawX(x_a), .DrawY(y_a),
    .hs(hs_a), .vs(vs_a), .blank(blank_a), .line_tick(lt_a), .frame_tick(ft_a),
    .vsync_toggle(tog_a)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .CLK(clk), .RESET(rst), .pixel_clk(pclk_s), .pix_en(pe_s), .DrawX(x_s), .DrawY(y_s),
    .hs(hs_s), .vs(vs_s), .blank(blank_s), .line_tick(lt_s), .frame_tick(ft_s),
    .vsync_toggle(tog_s)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_1 (
    .CLK(clk), .RESET(rst), .pixel_clk(pclk_1), .pix_en(pe_1), .DrawX(x_1), .DrawY(y_1),
    .hs(hs_1), .vs(vs_1), .blank(blank_1), .line_tick(lt_1), .frame_tick(ft_1),
    .vsync_toggle(tog_1)
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs from the cycle count since reset release (cycle 0 = reset state).
  function automatic out_t model(int c, int d, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    out_t o;
    int ht, vt, p, fp, x, y, vss, hits;
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    p    = c / d;
    fp   = p % (ht * vt);
    x    = fp % ht;
    y    = fp / ht;
    o.pe    = ((c % d) == d - 1);
    o.pclk  = (d >= 2) && ((c % d) < d / 2);
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    o.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    o.blank = (x < hv) && (y < vv);
    o.lt    = (c > 0) && ((c % d) == 0) && (x == 0);
    o.ft    = o.lt && (y == 0);
    vss     = (vv + vf) * ht;
    hits    = (p >= vss) ? ((p - vss) / (ht * vt) + 1) : 0;
    o.tog   = hits[0];
    return o;
  endfunction

  function automatic out_t model_s(int c);
    return model(c, 2, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic out_t model_1(int c);
    return model(c, 1, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic out_t mk(logic pclk, logic pe, int x, int y, logic hs, logic vs,
                              logic blank, logic lt, logic ft, logic tog);
    out_t o;
    o.pclk = pclk; o.pe = pe; o.x = 10'(x); o.y = 10'(y); o.hs = hs; o.vs = vs;
    o.blank = blank; o.lt = lt; o.ft = ft; o.tog = tog;
    return o;
  endfunction

  task automatic check(string name, int c, out_t got, out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got pclk=%0b pe=%0b x=%0d y=%0d hs=%0b vs=%0b blank=%0b lt=%0b ft=%0b tog=%0b required pclk=%0b pe=%0b x=%0d y=%0d hs=%0b vs=%0b blank=%0b lt=%0b ft=%0b tog=%0b",
               name, c, got.pclk, got.pe, got.x, got.y, got.hs, got.vs, got.blank, got.lt,
               got.ft, got.tog, exp.pclk, exp.pe, exp.x, exp.y, exp.hs, exp.vs, exp.blank,
               exp.lt, exp.ft, exp.tog);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 with RESET low.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[13];
  int   exp_tog[3];

  initial begin
    int idx, lt_cnt;
    int last_ft_s, last_ft_1, ft_cnt_s, ft_cnt_1, vs_low_s, vs_low_1;
    logic prev_tog;
    logic tog_seq[$];

    // Default timing, first line: x advances every 2 CLK, wrap at cycle 1600.
    tbl[0]  = '{0,    mk(1, 0,   0, 0, 1, 1, 1, 0, 0, 0)};
    tbl[1]  = '{1,    mk(0, 1,   0, 0, 1, 1, 1, 0, 0, 0)};
    tbl[2]  = '{2,    mk(1, 0,   1, 0, 1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{1279, mk(0, 1, 639, 0, 1, 1, 1, 0, 0, 0)};
    tbl[4]  = '{1280, mk(1, 0, 640, 0, 1, 1, 0, 0, 0, 0)};
    tbl[5]  = '{1311, mk(0, 1, 655, 0, 1, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1312, mk(1, 0, 656, 0, 0, 1, 0, 0, 0, 0)};
    tbl[7]  = '{1503, mk(0, 1, 751, 0, 0, 1, 0, 0, 0, 0)};
    tbl[8]  = '{1504, mk(1, 0, 752, 0, 1, 1, 0, 0, 0, 0)};
    tbl[9]  = '{1599, mk(0, 1, 799, 0, 1, 1, 0, 0, 0, 0)};
    tbl[10] = '{1600, mk(1, 0,   0, 1, 1, 1, 1, 1, 0, 0)};
    tbl[11] = '{1601, mk(0, 1,   0, 1, 1, 1, 1, 0, 0, 0)};
    tbl[12] = '{1602, mk(1, 0,   1, 1, 1, 1, 1, 0, 0, 0)};
    exp_tog = '{1, 0, 1};

    // Reset release and first line at default timing.
    do_reset();
    idx    = 0;
    lt_cnt = 0;
    for (int c = 0; c <= 1602; c++) begin
      if (c > 0) @(negedge clk);
      if (lt_a) lt_cnt++;
      if (idx < 13 && tbl[idx].cyc == c) begin
        check("line_vec", c, got_a, tbl[idx].exp);
        idx++;
      end
    end
    check_int("line_tick_count", lt_cnt, 1);

    // Three reduced frames (div 2) and six reduced frames (div 1).
    do_reset();
    last_ft_s = -1; last_ft_1 = -1; ft_cnt_s = 0; ft_cnt_1 = 0;
    vs_low_s  = 0;  vs_low_1  = 0;  prev_tog = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (c > 0) @(negedge clk);
      check("frame_s", c, got_s, model_s(c));
      check("frame_1", c, got_1, model_1(c));
      if (ft_s) begin
        if (last_ft_s >= 0) check_int("frame_period_s", c - last_ft_s, 360);
        last_ft_s = c;
        ft_cnt_s++;
      end
      if (ft_1) begin
        if (last_ft_1 >= 0) check_int("frame_period_1", c - last_ft_1, 180);
        last_ft_1 = c;
        ft_cnt_1++;
      end
      if (!vs_s) vs_low_s++;
      if (!vs_1) vs_low_1++;
      if (tog_s !== prev_tog) begin
        tog_seq.push_back(tog_s);
        prev_tog = tog_s;
      end
    end
    check_int("frame_count_s", ft_cnt_s, 3);
    check_int("frame_count_1", ft_cnt_1, 6);
    check_int("vs_low_cycles_s", vs_low_s, 180);
    check_int("vs_low_cycles_1", vs_low_1, 180);
    check_int("tog_changes", tog_seq.size(), 3);
    if (tog_seq.size() == 3) begin
      for (int i = 0; i < 3; i++) check_int("tog_seq", int'(tog_seq[i]), exp_tog[i]);
    end

    // Mid-frame reset: dut_s at x=10,y=6; dut_1 has its toggle set.
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      if (c > 0) @(negedge clk);
      check("pre_rst_s", c, got_s, model_s(c));
      check("pre_rst_1", c, got_1, model_1(c));
    end
    check("pre_rst_pos", 200, got_s, mk(1, 0, 10, 6, 0, 1, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_a", 0, got_a, mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    check("rst_s", 0, got_s, mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    check("rst_1", 0, got_1, mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      check("restart_s", c, got_s, model_s(c));
      check("restart_1", c, got_1, model_1(c));
      check("restart_a", c, got_a, model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
